dmem_boot_arbiter: RTL and testbench

//   Owns the MIPS data memory port. After reset it zero-fills the memory, then lets a host

---
 rtl/dmem_boot_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_boot_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_boot_arbiter.sv
// Purpose: owns the data memory port; zero-fills memory after reset, then serves host loads/stores and arbitrates the port between core and host.
// Latency: memory, ack and stall outputs are combinational from state and inputs; a transfer completes on the edge that ends its ack cycle.
// Backpressure: the core wins in RUN; a host request blocked for STARVE_LIM cycles is forced through and stalls the core for that cycle.
module dmem_boot_arbiter #(
    parameter  int DEPTH      = 32,
    parameter  int DATA_W     = 32,
    parameter  int STARVE_LIM = 4,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_go,
    input  logic              host_halt,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              core_re,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              cpu_rst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   clr_addr;   // one extra bit so the terminal count needs no wrap
    logic [CNT_W-1:0]  wait_cnt;
    logic              core_acc;
    logic              starved;

    assign core_acc   = core_re | core_we;
    assign starved    = (wait_cnt == CNT_W'(STARVE_LIM));
    assign host_rdata = mem_rdata;
    assign core_rdata = mem_rdata;
    assign busy       = (state == ST_CLEAR);

    // Next state plus port steering: fill in CLEAR, host-only in LOAD, core-first in RUN
    always_comb begin
        state_nx   = state;
        mem_we     = 1'b0;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        host_ack   = 1'b0;
        core_stall = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_addr[ADDR_W-1:0];
                mem_wdata = '0;
                if (clr_addr == (ADDR_W+1)'(DEPTH - 1)) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                if (host_req) begin
                    mem_we   = host_we;
                    host_ack = 1'b1;
                end
                if (host_go) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (host_req && (!core_acc || starved)) begin
                    // Host slot: either the core is idle or the host has waited long enough
                    mem_we     = host_we;
                    mem_addr   = host_addr;
                    mem_wdata  = host_wdata;
                    host_ack   = 1'b1;
                    core_stall = core_acc;
                end else begin
                    mem_we = core_we;
                end
                if (host_halt) begin
                    state_nx = ST_LOAD;
                end
            end
            default: begin
                state_nx = ST_CLEAR;
            end
        endcase
    end

    // State register; the core is held in reset whenever the next state is not RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            cpu_rst <= 1'b1;
        end else begin
            state   <= state_nx;
            cpu_rst <= (state_nx != ST_RUN);
        end
    end

    // Fill address advances once per CLEAR cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + (ADDR_W+1)'(1);
        end
    end

    // Starvation counter: counts RUN cycles a host request is blocked, clears when served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (host_ack) begin
            wait_cnt <= '0;
        end else if ((state == ST_RUN) && host_req && !starved) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmem_boot_arbiter.sv
// Purpose: directed check of fill, host load, core/host arbitration, starvation guard and async reset.
// Latency: samples outputs 1-2 time units after the falling edge, inputs driven 1 unit after it.
// Backpressure: host_req is held until host_ack, matching the host handshake.
module tb_dmem_boot_arbiter;

    logic        clk;
    logic        rst;
    logic        host_req;
    logic        host_we;
    logic [4:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_go;
    logic        host_halt;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        core_re;
    logic        core_we;
    logic [4:0]  core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        cpu_rst;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] mem [0:31];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hreq;
        logic        hwe;
        logic [4:0]  haddr;
        logic [31:0] hwdata;
        logic        go;
        logic        halt;
        logic        cre;
        logic        cwe;
        logic [4:0]  caddr;
        logic [31:0] cwdata;
        logic        e_ack;
        logic        e_stall;
        logic        e_crst;
        logic        e_mwe;
        logic [4:0]  e_maddr;
        logic [31:0] e_mwdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [11];

    dmem_boot_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_go    (host_go),
        .host_halt  (host_halt),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .core_re    (core_re),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .cpu_rst    (cpu_rst),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory model: asynchronous read, synchronous write
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        host_req   = v.hreq;
        host_we    = v.hwe;
        host_addr  = v.haddr;
        host_wdata = v.hwdata;
        host_go    = v.go;
        host_halt  = v.halt;
        core_re    = v.cre;
        core_we    = v.cwe;
        core_addr  = v.caddr;
        core_wdata = v.cwdata;
    endtask

    task automatic idle_inputs();
        host_req = 1'b0; host_we = 1'b0; host_addr = 5'd0; host_wdata = 32'd0;
        host_go = 1'b0; host_halt = 1'b0;
        core_re = 1'b0; core_we = 1'b0; core_addr = 5'd0; core_wdata = 32'd0;
    endtask

    initial begin
        int nonzero;
        int ack_cyc;
        int stall_bad;

        //            hreq  hwe   haddr  hwdata  go    halt  cre   cwe   caddr  cwdata | ack  stall crst  mwe   maddr  mwdata  rdata
        vecs[0]  = '{1'b1, 1'b1, 5'd0, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'd5,  32'd0};
        vecs[1]  = '{1'b1, 1'b1, 5'd1, 32'd6,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'd6,  32'd0};
        vecs[2]  = '{1'b1, 1'b1, 5'd2, 32'd7,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'd7,  32'd0};
        vecs[3]  = '{1'b1, 1'b0, 5'd1, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'd0,  32'd6};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,  32'd5};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd20, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd20, 32'd0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'd0,  32'd20};
        vecs[7]  = '{1'b1, 1'b0, 5'd2, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'd0,  32'd7};
        vecs[8]  = '{1'b1, 1'b1, 5'd4, 32'd9,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  32'd5};
        vecs[9]  = '{1'b1, 1'b1, 5'd4, 32'd9,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'd9,  32'd0};
        vecs[10] = '{1'b1, 1'b0, 5'd4, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'd0,  32'd9};

        for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        rst = 1'b1;
        idle_inputs();

        // Reset state
        step();
        #1;
        check("reset_outputs", 128'({mem_we, mem_addr, mem_wdata, host_ack, core_stall, busy, cpu_rst}),
              128'({1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1}));

        // T1: fill of 32 words after reset release
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("fill_%0d", i), 128'({mem_we, mem_addr, mem_wdata, busy}),
                  128'({1'b1, 5'(i), 32'd0, 1'b1}));
            step();
        end
        check("fill_done", 128'({busy, mem_we, cpu_rst}), 128'({1'b0, 1'b0, 1'b1}));
        nonzero = 0;
        for (int i = 0; i < 32; i++) if (mem[i] != 32'd0) nonzero++;
        check("fill_all_zero", 128'(nonzero), 128'(0));

        // T2/T3 and RUN arbitration vectors
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("vec_%0d", i),
                  128'({host_ack, core_stall, cpu_rst, mem_we, mem_addr, mem_wdata, host_rdata, core_rdata, busy}),
                  128'({vecs[i].e_ack, vecs[i].e_stall, vecs[i].e_crst, vecs[i].e_mwe, vecs[i].e_maddr,
                        vecs[i].e_mwdata, vecs[i].e_rdata, vecs[i].e_rdata, 1'b0}));
            step();
        end

        // T4: core holds the port, host read is forced through after STARVE_LIM blocked cycles
        idle_inputs();
        core_re   = 1'b1;
        core_addr = 5'd0;
        host_req  = 1'b1;
        host_addr = 5'd2;
        ack_cyc   = 0;
        stall_bad = 0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (host_ack) begin
                ack_cyc = c;
                check("t4_stall_on_ack", 128'(core_stall), 128'(1'b1));
                check("t4_forced_port", 128'({mem_we, mem_addr, host_rdata}), 128'({1'b0, 5'd2, 32'd7}));
                step();
                host_req = 1'b0;
                break;
            end else begin
                if (core_stall || mem_addr != 5'd0) stall_bad++;
                step();
            end
        end
        check("t4_ack_cycle", 128'(ack_cyc), 128'(5));
        check("t4_core_before_ack", 128'(stall_bad), 128'(0));
        #1;
        check("t4_after", 128'({host_ack, core_stall, mem_addr}), 128'({1'b0, 1'b0, 5'd0}));
        step();

        // T5: halt with idle core and pending host read
        idle_inputs();
        host_req  = 1'b1;
        host_addr = 5'd1;
        host_halt = 1'b1;
        #1;
        check("t5_halt_read", 128'({host_ack, host_rdata, cpu_rst}), 128'({1'b1, 32'd6, 1'b0}));
        step();
        idle_inputs();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd5;
        host_wdata = 32'd11;
        core_re    = 1'b1;
        #1;
        check("t5_in_load", 128'({cpu_rst, host_ack, core_stall, mem_we, mem_addr}),
              128'({1'b1, 1'b1, 1'b0, 1'b1, 5'd5}));
        step();

        // Async reset while running
        idle_inputs();
        host_go = 1'b1;
        step();
        host_go = 1'b0;
        #1;
        check("run_entry", 128'(cpu_rst), 128'(1'b0));
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_run", 128'({cpu_rst, busy, mem_we, mem_addr, mem_wdata}),
              128'({1'b1, 1'b1, 1'b1, 5'd0, 32'd0}));
        step();

        // T6: reset at clr_addr 17 restarts the fill; host is ignored during CLEAR
        rst        = 1'b0;
        host_go    = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd9;
        host_wdata = 32'd99;
        for (int i = 0; i < 17; i++) step();
        check("t6_mid", 128'({mem_addr, mem_we, mem_wdata, host_ack, busy}),
              128'({5'd17, 1'b1, 32'd0, 1'b0, 1'b1}));
        rst = 1'b1;
        #1;
        check("t6_rst_addr", 128'({mem_addr, busy, cpu_rst}), 128'({5'd0, 1'b1, 1'b1}));
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("refill_%0d", i), 128'({mem_we, mem_addr, mem_wdata, host_ack, busy}),
                  128'({1'b1, 5'(i), 32'd0, 1'b0, 1'b1}));
            step();
        end
        check("refill_done", 128'({busy, cpu_rst, host_ack, mem_we, mem_addr}),
              128'({1'b0, 1'b1, 1'b1, 1'b1, 5'd9}));
        step();
        idle_inputs();
        #1;
        check("go_after_fill", 128'(cpu_rst), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
